// File: rtl/wishbone_arbiter_pkg.sv
// Shared constants, bus widths and FSM state encoding for the
// Wishbone arbiter (IF/MEM requesters onto one Wishbone master).
package wishbone_arbiter_pkg;

  localparam int          REG_BUS    = 32;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [3:0]  WB_SEL_ALL = 4'b1111;
  localparam logic        STOP       = 1'b1;
  localparam logic        NO_STOP    = 1'b0;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    IF_RD      = 3'd1,
    MEM_RD     = 3'd2,
    MEM_RMW_RD = 3'd3,
    MEM_WR     = 3'd4
  } arb_state_e;

endpackage

// File: rtl/wb_byte_merge.sv
// Combinational byte merge: byte lanes with sel_i=1 take new_i,
// others keep old_i. Ports: sel_i, old_i, new_i -> merged_o.
module wb_byte_merge
  import wishbone_arbiter_pkg::*;
(
  input  logic [3:0]         sel_i,
  input  logic [REG_BUS-1:0] old_i,
  input  logic [REG_BUS-1:0] new_i,
  output logic [REG_BUS-1:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int b = 0; b < 4; b++) begin
      if (sel_i[b]) merged_o[8*b +: 8] = new_i[8*b +: 8];
    end
  end

endmodule

// File: rtl/wishbone_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one registered
// Wishbone master; sub-word stores run as read-merge-write.
// Ports: clk, rst (sync, active-high), flush_i; IF req/addr ->
// data/ready/stall; MEM req/we/sel/addr/data -> data/ready/stall;
// wb_* master outputs, wb_data_i/wb_ack_i; bus_err_o.
// Optional BUS_TIMEOUT_EN: abort after TIMEOUT_CYCLES without ack.
module wishbone_arbiter
  import wishbone_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               if_req_i,
  input  logic [REG_BUS-1:0] if_addr_i,
  output logic [REG_BUS-1:0] if_data_o,
  output logic               if_ready_o,
  output logic               stall_req_if,
  input  logic               mem_req_i,
  input  logic               mem_we_i,
  input  logic [3:0]         mem_sel_i,
  input  logic [REG_BUS-1:0] mem_addr_i,
  input  logic [REG_BUS-1:0] mem_data_i,
  output logic [REG_BUS-1:0] mem_data_o,
  output logic               mem_ready_o,
  output logic               stall_req_mem,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  output logic [3:0]         wb_sel_o,
  output logic [REG_BUS-1:0] wb_addr_o,
  output logic [REG_BUS-1:0] wb_data_o,
  input  logic [REG_BUS-1:0] wb_data_i,
  input  logic               wb_ack_i,
  output logic               bus_err_o
);

  arb_state_e         state_q, state_d;
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic               we_q, we_d;
  logic [3:0]         sel_q, sel_d;
  logic [3:0]         msel_q, msel_d;
  logic [REG_BUS-1:0] addr_q, addr_d;
  logic [REG_BUS-1:0] wdata_q, wdata_d;
  logic [REG_BUS-1:0] if_data_q, if_data_d;
  logic [REG_BUS-1:0] mem_data_q, mem_data_d;
  logic               if_ready_q, if_ready_d;
  logic               mem_ready_q, mem_ready_d;
  logic               flush_q, flush_d;
  logic [REG_BUS-1:0] merged;
  logic               ack;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
    $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
  assign bus_err_o = bus_err_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign bus_err_o = 1'b0;
`endif

  // Acks are only meaningful while a strobe is out.
  assign ack = wb_ack_i & stb_q;

  wb_byte_merge u_merge (
    .sel_i   (msel_q),
    .old_i   (wb_data_i),
    .new_i   (wdata_q),
    .merged_o(merged)
  );

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    msel_d      = msel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_data_d   = if_data_q;
    mem_data_d  = mem_data_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    flush_d     = flush_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d       = cnt_q;
    bus_err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // A ready pulse blocks re-acceptance of the same request.
        if (mem_req_i && !mem_ready_q) begin
          addr_d  = mem_addr_i;
          wdata_d = mem_data_i;
          msel_d  = mem_sel_i;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          if (!mem_we_i) begin
            state_d = MEM_RD;
            sel_d   = mem_sel_i;
            we_d    = 1'b0;
          end else if (mem_sel_i == WB_SEL_ALL) begin
            state_d = MEM_WR;
            sel_d   = WB_SEL_ALL;
            we_d    = 1'b1;
          end else begin
            state_d = MEM_RMW_RD;
            sel_d   = WB_SEL_ALL;
            we_d    = 1'b0;
          end
        end else if (if_req_i && !if_ready_q && !flush_i) begin
          state_d = IF_RD;
          addr_d  = if_addr_i;
          sel_d   = WB_SEL_ALL;
          we_d    = 1'b0;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          flush_d = 1'b0;
        end
      end
      IF_RD: begin
        flush_d = flush_q | flush_i;
        if (ack) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          if (!(flush_q | flush_i)) begin
            if_ready_d = 1'b1;
            if_data_d  = wb_data_i;
          end
        end
      end
      MEM_RD: begin
        if (ack) begin
          state_d     = IDLE;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          mem_ready_d = 1'b1;
          mem_data_d  = wb_data_i;
        end
      end
      MEM_RMW_RD: begin
        // Bus idles one cycle before the merged write goes out.
        if (ack) begin
          state_d = MEM_WR;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b1;
          sel_d   = WB_SEL_ALL;
          wdata_d = merged;
        end
      end
      MEM_WR: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
        end else if (ack) begin
          state_d     = IDLE;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          mem_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
`ifdef BUS_TIMEOUT_EN
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!ack) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d   = IDLE;
        cyc_d     = 1'b0;
        stb_d     = 1'b0;
        bus_err_d = 1'b1;
        cnt_d     = '0;
        if (state_q == IF_RD) begin
          if_ready_d = !(flush_q | flush_i);
          if_data_d  = (flush_q | flush_i) ?
                       if_data_q : ZERO_WORD;
        end else begin
          mem_ready_d = 1'b1;
          mem_data_d  = ZERO_WORD;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'b0000;
      msel_q      <= 4'b0000;
      addr_q      <= ZERO_WORD;
      wdata_q     <= ZERO_WORD;
      if_data_q   <= ZERO_WORD;
      mem_data_q  <= ZERO_WORD;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      flush_q     <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      msel_q      <= msel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_data_q   <= if_data_d;
      mem_data_q  <= mem_data_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      flush_q     <= flush_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign wb_addr_o   = addr_q;
  assign wb_data_o   = wdata_q;
  assign if_data_o   = if_data_q;
  assign mem_data_o  = mem_data_q;
  assign if_ready_o  = if_ready_q;
  assign mem_ready_o = mem_ready_q;

  assign stall_req_mem = (mem_req_i & ~mem_ready_q) ? STOP : NO_STOP;
  assign stall_req_if  = (if_req_i & ~if_ready_q) ? STOP : NO_STOP;

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Randomized bench for wishbone_arbiter: the bench plays both
// requesters and a word-addressed Wishbone slave memory.
module tb_wishbone_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ready_o;
  logic        stall_req_if;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ready_o;
  logic        stall_req_mem;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic        bus_err_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [16];
  logic [31:0] exp_if_data;
  logic [31:0] exp_mem_data;

  wishbone_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_data_o    (if_data_o),
    .if_ready_o   (if_ready_o),
    .stall_req_if (stall_req_if),
    .mem_req_i    (mem_req_i),
    .mem_we_i     (mem_we_i),
    .mem_sel_i    (mem_sel_i),
    .mem_addr_i   (mem_addr_i),
    .mem_data_i   (mem_data_i),
    .mem_data_o   (mem_data_o),
    .mem_ready_o  (mem_ready_o),
    .stall_req_mem(stall_req_mem),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_we_o      (wb_we_o),
    .wb_sel_o     (wb_sel_o),
    .wb_addr_o    (wb_addr_o),
    .wb_data_o    (wb_data_o),
    .wb_data_i    (wb_data_i),
    .wb_ack_i     (wb_ack_i),
    .bus_err_o    (bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge_ref(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0] sel);
    logic [31:0] m;
    m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (new_w & m) | (old_w & ~m);
  endfunction

  task automatic step(input bit drop_mem);
    @(posedge clk);
    #1;
    wb_ack_i = 1'b0;
    if (drop_mem) mem_req_i = 1'b0;
    @(negedge clk);
  endtask

  // k strobe cycles with ack in the last one; slave serves mem[].
  task automatic bus_phase(input logic [31:0] addr, input logic we,
                           input logic [3:0] sel, input logic [31:0] wd,
                           input int k, input bit mstall,
                           input bit rflush, input bit drop_mem);
    for (int c = 1; c <= k; c++) begin
      step(drop_mem && c == 1);
      check("cyc", 32'(wb_cyc_o), 32'd1);
      check("stb", 32'(wb_stb_o), 32'd1);
      check("addr", wb_addr_o, addr);
      check("we", 32'(wb_we_o), 32'(we));
      check("sel", 32'(wb_sel_o), 32'(sel));
      if (we) check("wdata", wb_data_o, wd);
      if (mstall) check("stall_mem", 32'(stall_req_mem), 32'd1);
      if (rflush) flush_i = 1'($urandom_range(0, 1));
      if (c == k) begin
        wb_ack_i = 1'b1;
        if (we) mem[addr[5:2]] = wb_data_o;
        else wb_data_i = mem[addr[5:2]];
      end else begin
        wb_data_i = $urandom;
      end
    end
  endtask

  task automatic mem_txn(input logic we, input logic [3:0] sel,
                         input logic [3:0] idx, input logic [31:0] d,
                         input int k1, input int k2);
    logic [31:0] addr;
    logic [31:0] old_w;
    addr = 32'h8000_0000 | {26'b0, idx, 2'b00};
    @(posedge clk);
    #1;
    wb_ack_i = 1'b0;
    mem_req_i = 1'b1;
    mem_we_i = we;
    mem_sel_i = sel;
    mem_addr_i = addr;
    mem_data_i = d;
    flush_i = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("mem_acc_cyc", 32'(wb_cyc_o), 32'd0);
    check("mem_acc_stall", 32'(stall_req_mem), 32'd1);
    if (!we) begin
      bus_phase(addr, 1'b0, sel, 32'd0, k1, 1, 1, 0);
      exp_mem_data = mem[idx];
    end else if (sel == 4'hF) begin
      bus_phase(addr, 1'b1, 4'hF, d, k1, 1, 1, 0);
    end else begin
      old_w = mem[idx];
      bus_phase(addr, 1'b0, 4'hF, 32'd0, k1, 1, 1, 0);
      step(0);
      check("rmw_gap_cyc", 32'(wb_cyc_o), 32'd0);
      check("rmw_gap_stall", 32'(stall_req_mem), 32'd1);
      bus_phase(addr, 1'b1, 4'hF, merge_ref(old_w, d, sel), k2, 1, 1, 0);
    end
    step(0);
    check("mem_ready", 32'(mem_ready_o), 32'd1);
    check("mem_data", mem_data_o, exp_mem_data);
    check("mem_rdy_stall", 32'(stall_req_mem), 32'd0);
    check("mem_rdy_cyc", 32'(wb_cyc_o), 32'd0);
    check("mem_rdy_ifr", 32'(if_ready_o), 32'd0);
    check("mem_rdy_err", 32'(bus_err_o), 32'd0);
    @(posedge clk);
    #1;
    mem_req_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk);
    check("mem_pulse", 32'(mem_ready_o), 32'd0);
    check("mem_no_reacc", 32'(wb_cyc_o), 32'd0);
  endtask

  task automatic if_txn(input logic [3:0] idx, input int k,
                        input bit flush);
    logic [31:0] addr;
    addr = 32'h0000_1000 | {26'b0, idx, 2'b00};
    @(posedge clk);
    #1;
    wb_ack_i = 1'b0;
    if_req_i = 1'b1;
    if_addr_i = addr;
    flush_i = 1'b0;
    @(negedge clk);
    check("if_acc_cyc", 32'(wb_cyc_o), 32'd0);
    check("if_acc_stall", 32'(stall_req_if), 32'd1);
    bus_phase(addr, 1'b0, 4'hF, 32'd0, k, 0, 0, 0);
    if (flush) flush_i = 1'b1;
    else exp_if_data = mem[idx];
    step(0);
    check("if_ready", 32'(if_ready_o), 32'(!flush));
    check("if_data", if_data_o, exp_if_data);
    check("if_rdy_cyc", 32'(wb_cyc_o), 32'd0);
    check("if_rdy_stall", 32'(stall_req_if), 32'(flush));
    @(posedge clk);
    #1;
    if_req_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk);
    check("if_pulse", 32'(if_ready_o), 32'd0);
    check("if_no_reacc", 32'(wb_cyc_o), 32'd0);
  endtask

  // Both requesters together: MEM load first, then the fetch.
  task automatic both_txn(input logic [3:0] mi, input logic [3:0] ii,
                          input logic [3:0] sel, input int k1,
                          input int k2);
    logic [31:0] ma;
    logic [31:0] ia;
    ma = 32'h8000_0000 | {26'b0, mi, 2'b00};
    ia = 32'h0000_1000 | {26'b0, ii, 2'b00};
    @(posedge clk);
    #1;
    wb_ack_i = 1'b0;
    flush_i = 1'b0;
    mem_req_i = 1'b1;
    mem_we_i = 1'b0;
    mem_sel_i = sel;
    mem_addr_i = ma;
    if_req_i = 1'b1;
    if_addr_i = ia;
    @(negedge clk);
    check("both_acc_cyc", 32'(wb_cyc_o), 32'd0);
    bus_phase(ma, 1'b0, sel, 32'd0, k1, 1, 0, 0);
    exp_mem_data = mem[mi];
    step(0);
    check("both_mem_rdy", 32'(mem_ready_o), 32'd1);
    check("both_mem_data", mem_data_o, exp_mem_data);
    check("both_if_rdy0", 32'(if_ready_o), 32'd0);
    check("both_if_stall", 32'(stall_req_if), 32'd1);
    bus_phase(ia, 1'b0, 4'hF, 32'd0, k2, 0, 0, 1);
    exp_if_data = mem[ii];
    step(0);
    check("both_if_rdy", 32'(if_ready_o), 32'd1);
    check("both_if_data", if_data_o, exp_if_data);
    check("both_mem_rdy0", 32'(mem_ready_o), 32'd0);
    @(posedge clk);
    #1;
    if_req_i = 1'b0;
    @(negedge clk);
    check("both_if_pulse", 32'(if_ready_o), 32'd0);
    check("both_idle", 32'(wb_cyc_o), 32'd0);
  endtask

  task automatic idle_acks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      wb_ack_i = 1'($urandom_range(0, 1));
      wb_data_i = $urandom;
      @(negedge clk);
      check("idle_cyc", 32'(wb_cyc_o), 32'd0);
      check("idle_mrdy", 32'(mem_ready_o), 32'd0);
      check("idle_irdy", 32'(if_ready_o), 32'd0);
    end
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_cyc"}, 32'(wb_cyc_o), 32'd0);
    check({tag, "_stb"}, 32'(wb_stb_o), 32'd0);
    check({tag, "_we"}, 32'(wb_we_o), 32'd0);
    check({tag, "_sel"}, 32'(wb_sel_o), 32'd0);
    check({tag, "_addr"}, wb_addr_o, 32'd0);
    check({tag, "_wdata"}, wb_data_o, 32'd0);
    check({tag, "_ifdata"}, if_data_o, 32'd0);
    check({tag, "_memdata"}, mem_data_o, 32'd0);
    check({tag, "_ifrdy"}, 32'(if_ready_o), 32'd0);
    check({tag, "_memrdy"}, 32'(mem_ready_o), 32'd0);
    check({tag, "_err"}, 32'(bus_err_o), 32'd0);
  endtask

  initial begin
    int kind;
    rst = 1'b1;
    flush_i = 1'b0;
    if_req_i = 1'b0;
    if_addr_i = '0;
    mem_req_i = 1'b0;
    mem_we_i = 1'b0;
    mem_sel_i = '0;
    mem_addr_i = '0;
    mem_data_i = '0;
    wb_data_i = '0;
    wb_ack_i = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    exp_if_data = 32'd0;
    exp_mem_data = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_outputs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    mem[4] = 32'hDEAD_BEEF;
    mem_txn(1'b0, 4'hF, 4'd4, 32'd0, 3, 0);
    mem[5] = 32'h1122_3344;
    mem_txn(1'b1, 4'b0010, 4'd5, 32'h0000_AB00, 1, 1);
    check("rmw_word", mem[5], 32'h1122_AB44);
    mem_txn(1'b1, 4'hF, 4'd8, 32'hCAFE_F00D, 1, 0);
    check("wr_word", mem[8], 32'hCAFE_F00D);
    mem[6] = 32'h2400_0001;
    if_txn(4'd6, 2, 1);
    if_txn(4'd7, 1, 0);
    both_txn(4'd1, 4'd2, 4'hF, 2, 1);
    idle_acks(3);

    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: mem_txn(1'b0, 4'($urandom_range(1, 15)),
                   4'($urandom_range(0, 15)), 32'd0,
                   int'($urandom_range(1, 4)), 0);
        1: mem_txn(1'b1, 4'($urandom_range(1, 15)),
                   4'($urandom_range(0, 15)), $urandom,
                   int'($urandom_range(1, 4)),
                   int'($urandom_range(1, 4)));
        2: if_txn(4'($urandom_range(0, 15)),
                  int'($urandom_range(1, 4)), 1'($urandom_range(0, 3) == 0));
        default: both_txn(4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)),
                          4'($urandom_range(1, 15)),
                          int'($urandom_range(1, 4)),
                          int'($urandom_range(1, 4)));
      endcase
      idle_acks(int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a full-word write.
    @(posedge clk);
    #1;
    wb_ack_i = 1'b0;
    mem_req_i = 1'b1;
    mem_we_i = 1'b1;
    mem_sel_i = 4'hF;
    mem_addr_i = 32'h8000_0020;
    mem_data_i = 32'h5555_AAAA;
    @(negedge clk);
    step(0);
    check("wr_mid_we", 32'(wb_we_o), 32'd1);
    step(0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_req_i = 1'b0;
    @(negedge clk);
    reset_outputs("midrst");
    step(0);
    check("midrst_norelease", 32'(mem_ready_o), 32'd0);
    check("midrst_idle", 32'(wb_cyc_o), 32'd0);

    // Load that is never acknowledged.
    @(posedge clk);
    #1;
    mem_req_i = 1'b1;
    mem_we_i = 1'b0;
    mem_sel_i = 4'hF;
    mem_addr_i = 32'h8000_0030;
    @(negedge clk);
    for (int c = 0; c < TO; c++) begin
      step(0);
      check("to_cyc", 32'(wb_cyc_o), 32'd1);
      check("to_rdy", 32'(mem_ready_o), 32'd0);
    end
    step(0);
`ifdef BUS_TIMEOUT_EN
    check("to_err", 32'(bus_err_o), 32'd1);
    check("to_mrdy", 32'(mem_ready_o), 32'd1);
    check("to_mdata", mem_data_o, 32'd0);
    check("to_drop", 32'(wb_cyc_o), 32'd0);
    @(posedge clk);
    #1;
    mem_req_i = 1'b0;
    @(negedge clk);
    check("to_err_pulse", 32'(bus_err_o), 32'd0);
    check("to_rdy_pulse", 32'(mem_ready_o), 32'd0);
`else
    for (int c = 0; c < 20; c++) begin
      check("nto_cyc", 32'(wb_cyc_o), 32'd1);
      check("nto_rdy", 32'(mem_ready_o), 32'd0);
      check("nto_err", 32'(bus_err_o), 32'd0);
      step(0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_req_i = 1'b0;
    @(negedge clk);
    check("nto_rst_cyc", 32'(wb_cyc_o), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
